key_event_scheduler: RTL
========================

Name: key_event_scheduler

Overview:
- Sequences the four debounced key lines (Up, Down, Left, Right) into one stream of typed key events: PRESS, LONG, REPEAT, RELEASE.
- Runs one press/hold FSM per key and holds one pending-event slot per key.
- A round-robin arbiter shares a single registered event output between the four keys, using a valid/ready handshake.
- Sits between the key debounce layer and the UI/menu logic.

Parameters:
- CNT_W, 25, width of each per-key hold counter.
- LONG_CYCLES, 25000000, cycles a key is held before LONG is emitted (0.5 s at 50 MHz). Range 2..2^CNT_W-1.
- REPEAT_CYCLES, 5000000, cycles between REPEAT events after LONG. Range 2..2^CNT_W-1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- Key_Level  input  4  debounced key levels; 1 = pressed. Bit 3 = Up, bit 2 = Down, bit 1 = Left, bit 0 = Right.
- Evt_Valid  output  1  event register holds a valid event.
- Evt_Ready  input  1  consumer accepts the event when Evt_Valid && Evt_Ready at a clock edge.
- Evt_Key  output  2  index of the key that produced the event.
- Evt_Type  output  2  event type: 0 = PRESS, 1 = LONG, 2 = REPEAT, 3 = RELEASE.
- Overflow  output  4  sticky per-key flag; set when an event for that key was dropped.

Behaviour:
- Reset (RST=1 at an edge) clears:
  - Evt_Valid=0, Evt_Key=0, Evt_Type=0, Overflow=0.
  - All key FSMs to IDLE, all counters to 0, all pending slots empty.
  - Key_Level history register to 0.
  - Round-robin pointer to 3, so key 0 has first priority.
  - Reset mid-hold discards the hold. A key still pressed after reset produces a new PRESS, because the history register is 0.
- Edge detection: prev[k] is Key_Level[k] registered each cycle. Rise = Key_Level[k] & ~prev[k]. Fall = ~Key_Level[k] & prev[k].
- Per-key FSM:
  - IDLE: on rise, generate PRESS, cnt=0, go to PRESSED.
  - PRESSED: cnt increments each cycle. When cnt==LONG_CYCLES-1, generate LONG, cnt=0, go to HELD.
  - HELD: cnt increments each cycle. When cnt==REPEAT_CYCLES-1, generate REPEAT and set cnt=0 (feature-dependent, see Optional Feature).
  - Fall in PRESSED or HELD: generate RELEASE, go to IDLE. A fall takes priority over a LONG or REPEAT generated in the same cycle.
- Pending slot (one per key, holds a type):
  - A generated event is written to the slot if the slot is empty, or if the slot is granted in the same cycle. In the granted case the new event is kept and no overflow is flagged.
  - Otherwise the new event is dropped and Overflow[k] is set. Overflow clears only on reset.
- Arbiter and output register:
  - Load is allowed when Evt_Valid==0, or when Evt_Valid && Evt_Ready.
  - The arbiter grants the first non-empty slot, searching from pointer+1 upward modulo 4.
  - On grant: load Evt_Key and Evt_Type, set Evt_Valid=1, clear the slot, set pointer=granted index.
  - If no slot is pending and a handshake completes, Evt_Valid=0.
  - Evt_Key and Evt_Type are stable while Evt_Valid && !Evt_Ready.
- Latency:
  - A rise sampled at edge E writes the pending slot at E.
  - Evt_Valid is visible after edge E+1 if the output register is free.
  - Back-to-back throughput: one event per cycle with Evt_Ready held at 1.
- LONG timing: LONG is generated exactly LONG_CYCLES edges after the PRESS-generating edge.
- Simultaneous rises on several keys: all are pending together and are served in round-robin order, one per cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: HELD emits REPEAT every REPEAT_CYCLES cycles while the key is held, as described above.
- Undefined: HELD only waits for the fall; the counter is frozen and type 2 is never produced. The REPEAT_CYCLES parameter remains but is unused.

Test Plan (LONG_CYCLES=20, REPEAT_CYCLES=5, CNT_W=8, Evt_Ready=1 unless noted):
- Key_Level=4'b0001 for 3 cycles, then 0 -> events (Key 0, PRESS), then (Key 0, RELEASE); Evt_Valid first high 2 edges after the rise; no LONG; Overflow=0.
- Key 2 held for 32 cycles with KEY_REPEAT_EN defined -> PRESS, LONG at +20 edges, REPEAT at +25 and +30, RELEASE after the fall. Without the macro -> PRESS, LONG, RELEASE only.
- Key_Level 0 -> 4'b1111 in one cycle -> PRESS events for keys 0, 1, 2, 3 on 4 consecutive cycles; pointer ends at 3.
- Evt_Ready=0 while key 1 is pressed, released and pressed again -> output holds (Key 1, PRESS). The slot keeps RELEASE, the second PRESS is dropped, and Overflow=4'b0010.
- RST asserted for 1 cycle while key 3 is in HELD and still pressed -> all outputs 0; after reset, a fresh (Key 3, PRESS) is emitted.
- Evt_Ready toggled 1/0 each cycle with two keys pending -> every event is delivered exactly once, and data is stable while stalled.

Source files
------------

// File: rtl/key_event_scheduler_if.sv
// Event stream interface between the key event scheduler and its consumer.
// The scheduler drives the event register through the master modport; the
// consumer (UI/menu logic) uses the slave modport and drives Evt_Ready.
interface key_event_scheduler_if;
  logic       Evt_Valid;
  logic       Evt_Ready;
  logic [1:0] Evt_Key;
  logic [1:0] Evt_Type;

  modport master (
    output Evt_Valid,
    output Evt_Key,
    output Evt_Type,
    input  Evt_Ready
  );

  modport slave (
    input  Evt_Valid,
    input  Evt_Key,
    input  Evt_Type,
    output Evt_Ready
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Key event scheduler: turns four debounced key levels (3=Up, 2=Down,
// 1=Left, 0=Right) into a single stream of PRESS/LONG/REPEAT/RELEASE events.
// Each key has a press/hold FSM and a one-entry pending slot; a round-robin
// arbiter moves pending events into one registered valid/ready output.
// Optional macro KEY_REPEAT_EN: when defined, a held key emits REPEAT every
// REPEAT_CYCLES cycles after LONG; when undefined, HELD just waits for release.
module key_event_scheduler #(
  parameter int CNT_W         = 25,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            Key_Level,
  key_event_scheduler_if.master evt,
  output logic [3:0]            Overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_LONG    = 2'd1;
  localparam logic [1:0] T_REPEAT  = 2'd2;
  localparam logic [1:0] T_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Reject hold lengths the counters cannot represent meaningfully.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("key_event_scheduler: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [3:0]       prev_q;
  logic [3:0]       rise;
  logic [3:0]       fall;
  key_state_t       state_q [4];
  key_state_t       state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       gen;
  logic [1:0]       gen_type [4];

  logic [3:0]       pend_q;
  logic [1:0]       pend_type_q [4];
  logic [1:0]       ptr_q;

  logic             load_ok;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       search_idx;
  logic [3:0]       grant_onehot;

  assign rise = Key_Level & ~prev_q;
  assign fall = ~Key_Level & prev_q;

  // Key history, per-key FSM state and hold counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      prev_q <= Key_Level;
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Press/hold sequencing per key; a release beats LONG/REPEAT in the same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k]  = state_q[k];
      cnt_d[k]    = cnt_q[k];
      gen[k]      = 1'b0;
      gen_type[k] = T_PRESS;
      case (state_q[k])
        IDLE: begin
          if (rise[k]) begin
            gen[k]      = 1'b1;
            gen_type[k] = T_PRESS;
            cnt_d[k]    = '0;
            state_d[k]  = PRESSED;
          end
        end
        PRESSED: begin
          if (fall[k]) begin
            gen[k]      = 1'b1;
            gen_type[k] = T_RELEASE;
            state_d[k]  = IDLE;
          end else if (cnt_q[k] == LONG_LAST) begin
            gen[k]      = 1'b1;
            gen_type[k] = T_LONG;
            cnt_d[k]    = '0;
            state_d[k]  = HELD;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        HELD: begin
          if (fall[k]) begin
            gen[k]      = 1'b1;
            gen_type[k] = T_RELEASE;
            state_d[k]  = IDLE;
`ifdef KEY_REPEAT_EN
          end else if (cnt_q[k] == REPEAT_LAST) begin
            gen[k]      = 1'b1;
            gen_type[k] = T_REPEAT;
            cnt_d[k]    = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
`endif
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Round-robin pick of the first pending slot after the last granted key.
  always_comb begin
    load_ok      = !evt.Evt_Valid || evt.Evt_Ready;
    grant_any    = 1'b0;
    grant_idx    = 2'd0;
    search_idx   = 2'd0;
    grant_onehot = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      search_idx = ptr_q + 2'(i);
      if (load_ok && !grant_any && pend_q[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = search_idx;
      end
    end
    if (grant_any) begin
      grant_onehot = 4'b0001 << grant_idx;
    end
  end

  // Pending slots: accept a new event when empty or being drained, else flag overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q   <= 4'b0000;
      Overflow <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        pend_type_q[k] <= T_PRESS;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (gen[k]) begin
          if (!pend_q[k] || grant_onehot[k]) begin
            pend_q[k]      <= 1'b1;
            pend_type_q[k] <= gen_type[k];
          end else begin
            Overflow[k] <= 1'b1;
          end
        end else if (grant_onehot[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
    end
  end

  // Output event register and round-robin pointer; holds while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      evt.Evt_Valid <= 1'b0;
      evt.Evt_Key   <= 2'd0;
      evt.Evt_Type  <= 2'd0;
      ptr_q         <= 2'd3;
    end else if (load_ok) begin
      if (grant_any) begin
        evt.Evt_Valid <= 1'b1;
        evt.Evt_Key   <= grant_idx;
        evt.Evt_Type  <= pend_type_q[grant_idx];
        ptr_q         <= grant_idx;
      end else begin
        evt.Evt_Valid <= 1'b0;
      end
    end
  end

endmodule
